// File: rtl/cpu_bus_arbiter_if.sv
// Requester-side and cache-controller-side signals of the two-port bus arbiter.
// The arbiter uses the slave view; the surrounding system or bench uses the master view.
interface cpu_bus_arbiter_if;
  logic        cs0;
  logic        wr_rd0;
  logic [15:0] Address0;
  logic [7:0]  DOut0;
  logic        cs1;
  logic        wr_rd1;
  logic [15:0] Address1;
  logic [7:0]  DOut1;
  logic        ack0;
  logic        ack1;
  logic [7:0]  DIn;
  logic        timeout_err;
  logic        grant;
  logic        busy;
  logic        cc_cs;
  logic        cc_wr_rd;
  logic [15:0] cc_Address;
  logic [7:0]  cc_DOut;
  logic        cc_rdy;
  logic [7:0]  cc_DIn;

  // Handshake: cs is a level request held until a one-cycle ack; cc_cs is a
  // one-cycle strobe and the transaction is done on the first cycle cc_rdy is high.
  modport slave (
    input  cs0, wr_rd0, Address0, DOut0,
    input  cs1, wr_rd1, Address1, DOut1,
    input  cc_rdy, cc_DIn,
    output ack0, ack1, DIn, timeout_err, grant, busy,
    output cc_cs, cc_wr_rd, cc_Address, cc_DOut
  );

  modport master (
    output cs0, wr_rd0, Address0, DOut0,
    output cs1, wr_rd1, Address1, DOut1,
    output cc_rdy, cc_DIn,
    input  ack0, ack1, DIn, timeout_err, grant, busy,
    input  cc_cs, cc_wr_rd, cc_Address, cc_DOut
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing one cache-controller port between two CPU requesters,
// with a watchdog that aborts transactions the controller never completes.
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  cpu_bus_arbiter_if.slave bus,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       last_grant;
  logic       any_req;
  logic       pick;

  // On a tie the port that did not own the bus last time wins.
  always_comb begin
    any_req = bus.cs0 | bus.cs1;
    pick    = (bus.cs0 && bus.cs1) ? ~last_grant : bus.cs1;
  end

  assign bus.busy  = (state != S_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= 8'd0;
      last_grant      <= 1'b1;
      bus.grant       <= 1'b0;
      bus.cc_cs       <= 1'b0;
      bus.cc_wr_rd    <= 1'b0;
      bus.cc_Address  <= 16'd0;
      bus.cc_DOut     <= 8'd0;
      bus.ack0        <= 1'b0;
      bus.ack1        <= 1'b0;
      bus.DIn         <= 8'd0;
      bus.timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            bus.grant      <= pick;
            bus.cc_wr_rd   <= pick ? bus.wr_rd1   : bus.wr_rd0;
            bus.cc_Address <= pick ? bus.Address1 : bus.Address0;
            bus.cc_DOut    <= pick ? bus.DOut1    : bus.DOut0;
            bus.cc_cs      <= 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.cc_cs <= 1'b0;
          cnt       <= 8'd0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // A ready arriving on the watchdog's last cycle still completes normally.
          if (bus.cc_rdy) begin
            bus.DIn  <= bus.cc_DIn;
            bus.ack0 <= ~bus.grant;
            bus.ack1 <= bus.grant;
            state    <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            bus.DIn         <= 8'd0;
            bus.timeout_err <= 1'b1;
            bus.ack0        <= ~bus.grant;
            bus.ack1        <= bus.grant;
            state           <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          bus.ack0        <= 1'b0;
          bus.ack1        <= 1'b0;
          bus.timeout_err <= 1'b0;
          bus.DIn         <= 8'd0;
          last_grant      <= bus.grant;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed scenarios plus random traffic checked against
// a transaction-level model of arbitration order, latency and watchdog behaviour.
module tb_cpu_bus_arbiter;

  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_bus_arbiter_if bus();
  logic [1:0] fsm_state;

  cpu_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];   // {owner, timeout_err, DIn} of each expected ack

  logic        model_last;
  logic        pend[2];
  logic        req_wr[2];
  logic [15:0] req_addr[2];
  logic [7:0]  req_data[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input logic wr, input logic [15:0] a, input logic [7:0] d);
    pend[p]     = 1'b1;
    req_wr[p]   = wr;
    req_addr[p] = a;
    req_data[p] = d;
  endtask

  task automatic drive_reqs();
    bus.cs0      = pend[0];
    bus.wr_rd0   = req_wr[0];
    bus.Address0 = req_addr[0];
    bus.DOut0    = req_data[0];
    bus.cs1      = pend[1];
    bus.wr_rd1   = req_wr[1];
    bus.Address1 = req_addr[1];
    bus.DOut1    = req_data[1];
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cc_cs"}, bus.cc_cs, 0);
    chk({tag, "_cc_wr_rd"}, bus.cc_wr_rd, 0);
    chk({tag, "_cc_addr"}, bus.cc_Address, 0);
    chk({tag, "_cc_dout"}, bus.cc_DOut, 0);
    chk({tag, "_ack0"}, bus.ack0, 0);
    chk({tag, "_ack1"}, bus.ack1, 0);
    chk({tag, "_din"}, bus.DIn, 0);
    chk({tag, "_terr"}, bus.timeout_err, 0);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  // Called at the falling edge of an IDLE cycle (cycle 0). k is the cycle in which
  // cc_rdy is pulsed (<1 means never). Returns at the falling edge of the IDLE after RESP.
  task automatic run_txn(input int k, input logic [7:0] rdy_data, input logic keep,
                         output int owner);
    int   exp_ack;
    logic normal;
    logic exp_err;
    logic [7:0] exp_data;
    logic [9:0] want;
    drive_reqs();
    bus.cc_rdy = 1'b0;
    owner    = (pend[0] && pend[1]) ? (model_last ? 0 : 1) : (pend[0] ? 0 : 1);
    normal   = (k >= 2) && (k <= TO + 1);
    exp_ack  = normal ? k + 1 : TO + 2;
    exp_err  = ~normal;
    exp_data = normal ? rdy_data : 8'h00;
    exp_q.push_back({owner[0], exp_err, exp_data});
    for (int j = 1; j <= exp_ack; j++) begin
      @(negedge clk);
      chk("cc_cs", bus.cc_cs, (j == 1));
      chk("busy", bus.busy, 1);
      chk("grant", bus.grant, owner[0]);
      chk("cc_wr_rd", bus.cc_wr_rd, req_wr[owner]);
      chk("cc_addr", bus.cc_Address, req_addr[owner]);
      chk("cc_dout", bus.cc_DOut, req_data[owner]);
      chk("ack0", bus.ack0, (j == exp_ack) && (owner == 0));
      chk("ack1", bus.ack1, (j == exp_ack) && (owner == 1));
      if (j == exp_ack) begin
        want = exp_q.pop_front();
        chk("resp", {bus.ack1, bus.timeout_err, bus.DIn}, want);
        model_last = owner[0];
        if (!keep) pend[owner] = 1'b0;
        drive_reqs();
      end
      bus.cc_rdy = (j == k);
      bus.cc_DIn = (j == k) ? rdy_data : 8'($urandom);
    end
    @(negedge clk);
    bus.cc_rdy = 1'b0;
    chk("idle_busy", bus.busy, 0);
    chk("idle_ack", {bus.ack0, bus.ack1}, 0);
    chk("idle_terr", bus.timeout_err, 0);
    chk("idle_cc_cs", bus.cc_cs, 0);
  endtask

  // ---------------- test sequence ----------------
  int own;
  int k;
  logic r0, r1;

  initial begin
    model_last = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    set_req(0, 1'b0, 16'h0, 8'h0);
    set_req(1, 1'b0, 16'h0, 8'h0);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive_reqs();
    bus.cc_rdy = 1'b0;
    bus.cc_DIn = 8'h00;

    // Reset held with both requests active: outputs stay at zero.
    set_req(0, 1'($urandom), 16'($urandom), 8'($urandom));
    set_req(1, 1'($urandom), 16'($urandom), 8'($urandom));
    drive_reqs();
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    rst = 1'b0;
    run_txn(3, 8'($urandom), 1'b0, own);
    chk("first_grant", own, 0);
    run_txn(2, 8'($urandom), 1'b0, own);
    chk("second_grant", own, 1);

    // Single read at minimum latency.
    set_req(0, 1'b0, 16'h1234, 8'h00);
    run_txn(2, 8'hA5, 1'b0, own);

    // Contention on writes: leave port 1 as last owner, then both hold requests.
    set_req(1, 1'b1, 16'h5555, 8'h66);
    run_txn(4, 8'($urandom), 1'b0, own);
    set_req(0, 1'b1, 16'h0010, 8'h11);
    set_req(1, 1'b1, 16'h0020, 8'h22);
    for (int i = 0; i < 4; i++) begin
      run_txn(3, 8'($urandom), (i < 2), own);
      chk("rr_order", own, i % 2);
    end

    // Watchdog abort, then a normal completion.
    set_req(0, 1'b0, 16'hBEEF, 8'h00);
    run_txn(-1, 8'h00, 1'b0, own);
    set_req(1, 1'b0, 16'hCAFE, 8'h00);
    run_txn(3, 8'h3C, 1'b0, own);

    // Ready on the last WAIT cycle, and ready only during ISSUE.
    set_req(0, 1'b0, 16'h0A0A, 8'h00);
    run_txn(TO + 1, 8'hC3, 1'b0, own);
    set_req(1, 1'b1, 16'h0B0B, 8'h77);
    run_txn(1, 8'h99, 1'b0, own);

    // Random traffic.
    for (int n = 0; n < 30; n++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1 && !pend[0] && !pend[1]) r0 = 1'b1;
      if (r0 && !pend[0]) set_req(0, 1'($urandom), 16'($urandom), 8'($urandom));
      if (r1 && !pend[1]) set_req(1, 1'($urandom), 16'($urandom), 8'($urandom));
      k = $urandom_range(0, TO + 1);
      run_txn((k == 0) ? -1 : k, 8'($urandom), 1'($urandom_range(0, 3) == 0), own);
    end
    for (int n = 0; n < 4 && (pend[0] || pend[1]); n++)
      run_txn(2, 8'($urandom), 1'b0, own);

    // Reset in WAIT abandons the transaction; a stale ready afterwards does nothing.
    set_req(0, 1'b0, 16'h4242, 8'h00);
    drive_reqs();
    @(negedge clk);
    @(negedge clk);
    chk("rw_busy", bus.busy, 1);
    @(negedge clk);
    rst = 1'b1;
    pend[0] = 1'b0;
    drive_reqs();
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    check_reset_outputs("rw_reset");
    bus.cc_rdy = 1'b1;
    bus.cc_DIn = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.cc_rdy = 1'b0;
      chk("rw_ack", {bus.ack0, bus.ack1}, 0);
      chk("rw_idle", bus.busy, 0);
      chk("rw_cc_cs", bus.cc_cs, 0);
    end

    // Operation resumes with port 0 winning the first tie again.
    set_req(0, 1'b1, 16'h7001, 8'h01);
    set_req(1, 1'b1, 16'h7002, 8'h02);
    run_txn(2, 8'($urandom), 1'b0, own);
    chk("post_reset_grant", own, 0);
    run_txn(5, 8'($urandom), 1'b0, own);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
